// File: rtl/multiplication.sv
// rtl/multiplication.sv - sequential unsigned shift-and-add multiplier, one multiplier bit per clock
module multiplication #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        counter
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     mcand, mcand_next;
  logic [2*WIDTH:0]     acc, acc_next;
  logic [CW-1:0]        count, count_next;
  logic [WIDTH:0]       sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      mcand <= mcand_next;
      acc   <= acc_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    mcand_next = mcand;
    acc_next   = acc;
    count_next = count;
    // Partial sum keeps the carry in its top bit; it lands in acc[2W-1] after the shift.
    sum = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                 : {1'b0, acc[2*WIDTH-1:WIDTH]};
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          mcand_next = A;
          acc_next   = {{(WIDTH+1){1'b0}}, B};
          count_next = '0;
        end
      end
      RUN: begin
        acc_next   = {1'b0, sum, acc[WIDTH-1:1]};
        count_next = count + 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign prod    = acc[2*WIDTH-1:0];
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign counter = count;

endmodule

// File: tb/tb_multiplication.sv
// tb/tb_multiplication.sv - directed-vector bench for the shift-and-add multiplier
module tb_multiplication;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [WIDTH-1:0]    A = '0;
  logic [WIDTH-1:0]    B = '0;
  logic [2*WIDTH-1:0]  prod;
  logic                busy;
  logic                done;
  logic [CW-1:0]       counter;

  int total = 0;
  int bad   = 0;

  multiplication #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .prod(prod), .busy(busy), .done(done), .counter(counter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [63:0] exp);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = '1; B = '1;
    check({tag, "_busy0"}, 64'(busy), 64'd1);
    check({tag, "_cnt0"}, 64'(counter), 64'd0);
    repeat (WIDTH - 1) @(posedge clk);
    #1;
    check({tag, "_early"}, 64'(done), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cnt"}, 64'(counter), 64'd32);
    check({tag, "_prod"}, prod, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_prod", prod, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cnt", 64'(counter), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic", 32'd100, 32'd7, 64'h0000_0000_0000_02BC);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("zero", 32'd0, 32'h1234_5678, 64'd0);
    run_op("ident", 32'd1, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF);

    // start while busy must be ignored
    @(negedge clk);
    A = 32'd123; B = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    A = 32'd5; B = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_ign_cnt", 64'(counter), 64'd11);
    repeat (21) @(posedge clk);
    #1;
    check("busy_ign_done", 64'(done), 64'd1);
    check("busy_ign_prod", prod, 64'd12300);

    // reset mid-operation
    @(negedge clk);
    A = 32'd12345; B = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_prod", prod, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_cnt", 64'(counter), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 32'd288, 32'd7, 64'd2016);

    // start held high: back-to-back with one DONE cycle
    @(negedge clk);
    A = 32'd720; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    A = 32'hFFFF_FFFF; B = 32'd255;
    repeat (WIDTH) @(posedge clk);
    #1;
    check("b2b_done1", 64'(done), 64'd1);
    check("b2b_prod1", prod, 64'd5040);
    @(posedge clk); #1;
    check("b2b_done1_fall", 64'(done), 64'd0);
    check("b2b_restart_busy", 64'(busy), 64'd1);
    check("b2b_restart_cnt", 64'(counter), 64'd0);
    repeat (WIDTH - 1) @(posedge clk);
    #1;
    check("b2b_early2", 64'(done), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_prod2", prod, 64'h0000_00FE_FFFF_FF01);
    @(posedge clk); #1;
    check("b2b_hold_done", 64'(done), 64'd1);
    check("b2b_hold_prod", prod, 64'h0000_00FE_FFFF_FF01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
